// File: rtl/mac_controller10.sv
// rtl/mac_controller10.sv - length-programmed multiply-accumulate sequencer over a valid/ready operand stream

// Unsigned 16x16 combinational multiplier built from shifted partial products.
module shift_add_multiplier10 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o
);

  // Sum one shifted copy of a for each set bit of b.
  always_comb begin
    p_o = '0;
    for (int i = 0; i < 16; i++) begin
      if (b_i[i]) begin
        p_o = p_o + ({16'b0, a_i} << i);
      end
    end
  end

endmodule

// Controller: operand registers feed the shared multiplier, products fold into acc_q.
module mac_controller10 #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [LEN_W-1:0]   rem_q;
  logic [15:0]        op_a_q;
  logic [15:0]        op_b_q;
  logic               op_valid_q;
  logic [ACC_W-1:0]   acc_q;
  logic               ovf_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [31:0]        prod;
  logic [ACC_W:0]     acc_d;

  shift_add_multiplier10 u_mult (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (prod)
  );

  // Extra top bit of acc_d is the carry out of the accumulator.
  always_comb begin
    acc_d = {1'b0, acc_q} + (ACC_W + 1)'(prod);
  end

  // Sequencing FSM, operand capture, accumulation and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_valid_q  <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (clr) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_valid_q  <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (op_valid_q) begin
        acc_q <= acc_d[ACC_W-1:0];
        if (acc_d[ACC_W]) begin
          ovf_q <= 1'b1;
        end
      end
      op_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (len != '0) begin
              rem_q      <= len;
              state_q    <= RUN;
              in_ready_q <= 1'b1;
            end else begin
              // An empty job still spends one cycle before DONE so the
              // result appears one edge after start, like the len+1 rule.
              state_q <= DRAIN;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            op_a_q     <= in_a;
            op_b_q     <= in_b;
            op_valid_q <= 1'b1;
            rem_q      <= rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mac_controller10.sv
// tb/tb_mac_controller10.sv - directed self-checking bench for mac_controller10

module tb_mac_controller10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        clr;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_ready;

  logic        in_ready_w, out_valid_w, out_ovf_w, busy_w;
  logic [39:0] out_acc_w;
  logic        in_ready_n, out_valid_n, out_ovf_n, busy_n;
  logic [31:0] out_acc_n;

  int          n_checks;
  int          n_fails;
  logic [15:0] pa [8];
  logic [15:0] pb [8];
  int          ov_cyc;
  int          rdy_cnt;

  mac_controller10 #(.ACC_W(40), .LEN_W(8)) u_dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready_w),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid_w),
    .out_ready (out_ready),
    .out_acc   (out_acc_w),
    .out_ovf   (out_ovf_w),
    .busy      (busy_w)
  );

  mac_controller10 #(.ACC_W(32), .LEN_W(8)) u_dut_n (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready_n),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid_n),
    .out_ready (out_ready),
    .out_acc   (out_acc_n),
    .out_ovf   (out_ovf_n),
    .busy      (busy_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a job, feed n pairs from pa/pb with gap idle cycles after each accept,
  // optionally pulse start at cycle spulse; report edges until out_valid.
  task automatic job(input int jlen, input int n, input int gap, input int spulse,
                     output int ovc, output int rdy);
    int  idx;
    int  gapcnt;
    logic take;
    idx = 0; gapcnt = 0; ovc = -1; rdy = 0;
    len = 8'(jlen); start = 1'b1; in_valid = 1'b0;
    step();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid_w) begin
        ovc = c;
        break;
      end
      if (in_ready_w) rdy++;
      start = (c == spulse);
      take = in_ready_w && (idx < n) && (gapcnt == 0);
      in_valid = take;
      if (take) begin
        in_a = pa[idx];
        in_b = pb[idx];
      end
      step();
      if (take) begin
        idx++;
        gapcnt = gap;
      end else if (gapcnt > 0) begin
        gapcnt--;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_hs_valid", 64'(out_valid_w), 64'd0);
    check("post_hs_busy", 64'(busy_w), 64'd0);
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    rst_n = 1'b0; start = 1'b0; len = '0; clr = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) step();
    check("rst_in_ready", 64'(in_ready_w), 64'd0);
    check("rst_out_valid", 64'(out_valid_w), 64'd0);
    check("rst_out_acc", 64'(out_acc_w), 64'd0);
    check("rst_out_ovf", 64'(out_ovf_w), 64'd0);
    check("rst_busy", 64'(busy_w), 64'd0);
    rst_n = 1'b1;
    step();

    // Basic job
    pa[0] = 16'd3;     pb[0] = 16'd5;
    pa[1] = 16'd7;     pb[1] = 16'd11;
    pa[2] = 16'hFFFF;  pb[2] = 16'hFFFF;
    pa[3] = 16'd0;     pb[3] = 16'd9;
    job(4, 4, 0, -1, ov_cyc, rdy_cnt);
    check("basic_latency", 64'(ov_cyc), 64'd5);
    check("basic_ready_cycles", 64'(rdy_cnt), 64'd4);
    check("basic_acc", 64'(out_acc_w), 64'hFFFE005D);
    check("basic_ovf", 64'(out_ovf_w), 64'd0);
    check("basic_busy", 64'(busy_w), 64'd1);
    take_result();

    // Overflow on the 32-bit instance, no wrap on the 40-bit one
    pa[0] = 16'hFFFF; pb[0] = 16'hFFFF;
    pa[1] = 16'hFFFF; pb[1] = 16'hFFFF;
    job(2, 2, 0, -1, ov_cyc, rdy_cnt);
    check("ovf_latency", 64'(ov_cyc), 64'd3);
    check("ovf_acc32", 64'(out_acc_n), 64'hFFFC0002);
    check("ovf_flag32", 64'(out_ovf_n), 64'd1);
    check("ovf_acc40", 64'(out_acc_w), 64'h1FFFC0002);
    check("ovf_flag40", 64'(out_ovf_w), 64'd0);
    take_result();

    // Zero-length job with a result stall
    job(0, 0, 0, -1, ov_cyc, rdy_cnt);
    check("zero_latency", 64'(ov_cyc), 64'd1);
    check("zero_ready_cycles", 64'(rdy_cnt), 64'd0);
    check("zero_ovf_clear", 64'(out_ovf_w), 64'd0);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 64'(out_valid_w), 64'd1);
      check("stall_acc", 64'(out_acc_w), 64'd0);
      step();
    end
    take_result();

    // Gaps between pairs and a start pulse while running
    pa[0] = 16'd2; pb[0] = 16'd2;
    pa[1] = 16'd4; pb[1] = 16'd4;
    pa[2] = 16'd1; pb[2] = 16'd1;
    job(3, 3, 2, 3, ov_cyc, rdy_cnt);
    check("gap_latency", 64'(ov_cyc), 64'd8);
    check("gap_acc", 64'(out_acc_w), 64'd21);
    take_result();
    step();
    check("gap_no_queued_start", 64'(busy_w), 64'd0);

    // Abort after two accepted pairs, then a fresh job
    len = 8'd4; start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_a = 16'd9; in_b = 16'd9;
    step();
    step();
    in_valid = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_busy", 64'(busy_w), 64'd0);
    check("clr_in_ready", 64'(in_ready_w), 64'd0);
    check("clr_acc", 64'(out_acc_w), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("clr_no_valid", 64'(out_valid_w), 64'd0);
      step();
    end
    len = 8'd3; start = 1'b1; clr = 1'b1;
    step();
    start = 1'b0; clr = 1'b0;
    check("clr_beats_start", 64'(busy_w), 64'd0);
    pa[0] = 16'd10; pb[0] = 16'd10;
    job(1, 1, 0, -1, ov_cyc, rdy_cnt);
    check("restart_latency", 64'(ov_cyc), 64'd2);
    check("restart_acc", 64'(out_acc_w), 64'd100);
    check("restart_ovf", 64'(out_ovf_w), 64'd0);
    take_result();

    // Asynchronous reset while in DRAIN
    len = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_a = 16'd5; in_b = 16'd5;
    step();
    in_a = 16'd6; in_b = 16'd6;
    step();
    in_valid = 1'b0;
    check("drain_busy", 64'(busy_w), 64'd1);
    check("drain_in_ready", 64'(in_ready_w), 64'd0);
    check("drain_acc", 64'(out_acc_w), 64'd25);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy_w), 64'd0);
    check("arst_in_ready", 64'(in_ready_w), 64'd0);
    check("arst_out_valid", 64'(out_valid_w), 64'd0);
    check("arst_acc", 64'(out_acc_w), 64'd0);
    check("arst_ovf", 64'(out_ovf_w), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("arst_stays_idle", 64'(out_valid_w), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
